// File: rtl/conv_mac_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_mac_scheduler
//
// Sequencer for the convolver's fixed-point multiply datapath. One
// KERNEL_SIZE x KERNEL_SIZE window of weights and pixels is accepted per
// transaction. NUM_MULT signed multipliers are time-shared over the window,
// one group of NUM_MULT elements per cycle. Each product is rescaled by an
// arithmetic right shift of FRAC_BITS and accumulated. The sum is saturated
// to DATA_WIDTH and presented to the downstream stage.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high; aborts any transaction in flight
//   in_valid   : upstream window valid
//   in_ready   : high only in IDLE
//   weights    : element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   pixel_data : same packing as weights
//   out_valid  : result valid (DONE state)
//   out_ready  : downstream accepts result
//   result     : saturated signed sum of products
//   overflow   : result was clamped; qualified by out_valid
//   busy       : high in every state except IDLE
// -----------------------------------------------------------------------------
module conv_mac_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int NUM_MULT    = 5,
  parameter int FRAC_BITS   = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [(KERNEL_SIZE*KERNEL_SIZE)*DATA_WIDTH-1:0] weights,
  input  logic [(KERNEL_SIZE*KERNEL_SIZE)*DATA_WIDTH-1:0] pixel_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [DATA_WIDTH-1:0]                          result,
  output logic                                           overflow,
  output logic                                           busy
);

  localparam int NUM_ELEM   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_GROUPS = (NUM_ELEM + NUM_MULT - 1) / NUM_MULT;
  localparam int GRP_W      = NUM_MULT * DATA_WIDTH;
  localparam int PAD_W      = NUM_GROUPS * GRP_W;
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int ACC_W      = 2 * DATA_WIDTH + 8;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  // Operand registers are padded to a whole number of groups. The padding is
  // loaded with zeros so lanes past the last element contribute exactly 0.
  // Each MAC cycle shifts the next group down into lanes 0..NUM_MULT-1.
  logic [PAD_W-1:0]         r_weights;
  logic [PAD_W-1:0]         r_pixels;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_group;
  logic [DATA_WIDTH-1:0]    r_result;
  logic                     r_overflow;

  logic                     w_accept;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_lane [NUM_MULT];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [DATA_WIDTH-1:0]    w_sat;
  logic                     w_clip;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign overflow  = r_overflow;

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_group == CNT_W'(NUM_GROUPS - 1));

  // ---------------------------------------------------------------------------
  // Multiplier lanes
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < NUM_MULT; l++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] w_a;
    logic signed [DATA_WIDTH-1:0] w_b;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [PROD_W-1:0]     w_shift;

    assign w_a     = r_weights[l*DATA_WIDTH +: DATA_WIDTH];
    assign w_b     = r_pixels[l*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod  = w_a * w_b;
    // Arithmetic shift: rounds toward minus infinity, so -1 stays -1.
    assign w_shift = w_prod >>> FRAC_BITS;
    assign w_lane[l] = {{(ACC_W-PROD_W){w_shift[PROD_W-1]}}, w_shift};
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves it unassigned and no latch is inferred.
    w_sum = '0;
    for (int l = 0; l < NUM_MULT; l++) begin
      w_sum = w_sum + w_lane[l];
    end
  end

  assign w_acc_next = r_acc + w_sum;

  // Clamp to the signed DATA_WIDTH range of the output format.
  always_comb begin
    w_sat  = w_acc_next[DATA_WIDTH-1:0];
    w_clip = 1'b0;
    if (w_acc_next > SAT_MAX) begin
      w_sat  = SAT_MAX[DATA_WIDTH-1:0];
      w_clip = 1'b1;
    end else if (w_acc_next < SAT_MIN) begin
      w_sat  = SAT_MIN[DATA_WIDTH-1:0];
      w_clip = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_MAC;
      S_MAC:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the operand registers are reset too, so an aborted window leaves
    // nothing behind; this costs reset fan-out but the window is small.
    if (reset) begin
      r_weights  <= '0;
      r_pixels   <= '0;
      r_acc      <= '0;
      r_group    <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_weights <= PAD_W'(weights);
            r_pixels  <= PAD_W'(pixel_data);
            r_acc     <= '0;
            r_group   <= '0;
          end
        end
        S_MAC: begin
          r_acc     <= w_acc_next;
          r_group   <= r_group + 1'b1;
          r_weights <= r_weights >> GRP_W;
          r_pixels  <= r_pixels >> GRP_W;
          if (w_last) begin
            r_result   <= w_sat;
            r_overflow <= w_clip;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_mac_scheduler
//
// Two instances: dut0 with default parameters (G=5) and dut1 with NUM_MULT=4
// (G=7). A driver issues directed windows and pushes hand-computed results
// into a per-instance queue at acceptance; a monitor pops and compares on
// each rising out_valid, including the acceptance-to-valid latency.
// -----------------------------------------------------------------------------
module tb_conv_mac_scheduler;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int N  = K * K;
  localparam int WW = N * DW;
  localparam int G0 = 5;
  localparam int G1 = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          overflow  [2];
  logic          busy      [2];
  logic [WW-1:0] weights   [2];
  logic [WW-1:0] pixels    [2];
  logic [DW-1:0] result    [2];

  conv_mac_scheduler #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .NUM_MULT(5), .FRAC_BITS(8)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .weights(weights[0]), .pixel_data(pixels[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .overflow(overflow[0]), .busy(busy[0])
  );

  conv_mac_scheduler #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .NUM_MULT(4), .FRAC_BITS(8)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .weights(weights[1]), .pixel_data(pixels[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .overflow(overflow[1]), .busy(busy[1])
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
    int            acc_cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [WW-1:0] fill(input logic [DW-1:0] v);
    logic [WW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = v;
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic prev_valid [2];
  initial begin
    prev_valid[0] = 1'b0;
    prev_valid[1] = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    int   g;
    bool_empty_check: for (int d = 0; d < 2; d++) begin
      if (out_valid[d] === 1'b1 && prev_valid[d] !== 1'b1) begin
        g = (d == 0) ? G0 : G1;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          fail_now($sformatf("dut%0d unexpected result", d));
        end else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          check($sformatf("dut%0d result", d),   32'(result[d]),      32'(e.res));
          check($sformatf("dut%0d overflow", d), 32'(overflow[d]),    32'(e.ovf));
          check($sformatf("dut%0d latency", d),  32'(cyc - e.acc_cyc), 32'(g));
        end
      end
      prev_valid[d] = out_valid[d];
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic push_exp(input int d, input logic [DW-1:0] er, input logic eo, input int acc);
    exp_t e;
    e.res = er;
    e.ovf = eo;
    e.acc_cyc = acc;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Returns at the falling edge after the accepting edge (first MAC cycle).
  task automatic issue(input int d, input logic [WW-1:0] w, input logic [WW-1:0] p,
                       input logic [DW-1:0] er, input logic eo);
    int t;
    @(negedge clk);
    weights[d]  = w;
    pixels[d]   = p;
    in_valid[d] = 1'b1;
    t = 0;
    while (in_ready[d] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready[d] !== 1'b1) begin
      fail_now($sformatf("dut%0d accept", d));
      in_valid[d] = 1'b0;
      return;
    end
    push_exp(d, er, eo, cyc + 1);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (in_ready[d] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (in_ready[d] !== 1'b1) fail_now($sformatf("dut%0d return to idle", d));
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d in_ready", tag, d),  32'(in_ready[d]),  32'd1);
      check($sformatf("%s dut%0d out_valid", tag, d), 32'(out_valid[d]), 32'd0);
      check($sformatf("%s dut%0d result", tag, d),    32'(result[d]),    32'd0);
      check($sformatf("%s dut%0d overflow", tag, d),  32'(overflow[d]),  32'd0);
      check($sformatf("%s dut%0d busy", tag, d),      32'(busy[d]),      32'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [WW-1:0] w_sel;
    logic [WW-1:0] p_sel;
    int            bad;
    int            t;

    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      weights[d]   = '0;
      pixels[d]    = '0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    #2 check_reset_values("reset");
    #20 reset = 1'b0;

    // Directed windows on the default instance, each with the hand-computed sum.
    issue(0, fill(16'h0100), fill(16'h0100), 16'h1900, 1'b0); wait_idle(0); // 25 * 1.0
    issue(0, fill(16'hFF00), fill(16'h0200), 16'hCE00, 1'b0); wait_idle(0); // 25 * -2.0
    issue(0, fill(16'h0001), fill(16'hFFFF), 16'hFFE7, 1'b0); wait_idle(0); // 25 * -1 lsb
    issue(0, fill(16'h7FFF), fill(16'h7FFF), 16'h7FFF, 1'b1); wait_idle(0); // clamp high
    issue(0, fill(16'h7FFF), fill(16'h8000), 16'h8000, 1'b1); wait_idle(0); // clamp low
    issue(0, fill(16'h0080), fill(16'h0300), 16'h2580, 1'b0); wait_idle(0); // 25 * 1.5
    // Back-to-back at the minimum issue interval.
    issue(0, fill(16'h0100), fill(16'h0100), 16'h1900, 1'b0);
    issue(0, fill(16'h0080), fill(16'h0300), 16'h2580, 1'b0); wait_idle(0);

    // Partial last group on the NUM_MULT=4 instance: only element 24 nonzero.
    w_sel = '0;
    p_sel = '0;
    w_sel[24*DW +: DW] = 16'h0100;
    p_sel[24*DW +: DW] = 16'h0300;
    issue(1, w_sel, p_sel, 16'h0300, 1'b0); wait_idle(1);
    issue(1, fill(16'h0100), fill(16'h0100), 16'h1900, 1'b0); wait_idle(1);

    // Downstream stall in DONE with a competing window held upstream.
    @(negedge clk);
    out_ready[0] = 1'b0;
    issue(0, fill(16'h0100), fill(16'h0100), 16'h1900, 1'b0);
    t = 0;
    while (out_valid[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (out_valid[0] !== 1'b1) fail_now("stall out_valid");
    weights[0]  = fill(16'hFF00);
    pixels[0]   = fill(16'h0200);
    in_valid[0] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (result[0] !== 16'h1900 || in_ready[0] !== 1'b0 ||
          out_valid[0] !== 1'b1 || busy[0] !== 1'b1) bad++;
    end
    check("stall hold", 32'(bad), 32'd0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("release in_ready",  32'(in_ready[0]),  32'd1);
    check("release out_valid", 32'(out_valid[0]), 32'd0);
    check("release busy",      32'(busy[0]),      32'd0);
    check("release result",    32'(result[0]),    32'h1900);
    check("release overflow",  32'(overflow[0]),  32'd0);
    push_exp(0, 16'hCE00, 1'b0, cyc + 1);
    @(negedge clk);
    check("reaccept busy", 32'(busy[0]), 32'd1);
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Abort during the second MAC cycle; the next window must be clean.
    issue(0, fill(16'h7FFF), fill(16'h7FFF), 16'h7FFF, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("abort");
    if (sb0.size() > 0) void'(sb0.pop_back());
    #4 reset = 1'b0;
    issue(0, fill(16'h0100), fill(16'h0100), 16'h1900, 1'b0); wait_idle(0);

    // Drain: every expected result must have been seen.
    t = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("dut0 queue drained", 32'(sb0.size()), 32'd0);
    check("dut1 queue drained", 32'(sb1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
